fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that lets two producers share the write port of one 8-bit FIFO.
- Grants the FIFO write port to one requester at a time, for a burst of up to MAX_BURST words.
- Gates every write with the FIFO FULL flag, so no word is dropped.
- Sits directly in front of the FIFO write side: drives its WR_EN and FIFO_IN and consumes its FULL.

---
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between two producers, the write arbiter and the FIFO write side.
// Handshake: a word moves on a rising SYSCLK edge when REQn and ACKn are both high.
// REQn/DATAn must stay stable until ACKn is seen.
interface fifo_wr_arbiter_if #(
    parameter int DW = 8
);
    logic          REQ0;
    logic [DW-1:0] DATA0;
    logic          REQ1;
    logic [DW-1:0] DATA1;
    logic          FULL;
    logic          ACK0;
    logic          ACK1;
    logic          GNT0;
    logic          GNT1;
    logic          FIFO_WR_EN;
    logic [DW-1:0] FIFO_DATA;
    logic          BUSY;
    logic [1:0]    DBG_STATE;

    modport master (
        output REQ0, DATA0, REQ1, DATA1, FULL,
        input  ACK0, ACK1, GNT0, GNT1, FIFO_WR_EN, FIFO_DATA, BUSY, DBG_STATE
    );

    modport slave (
        input  REQ0, DATA0, REQ1, DATA1, FULL,
        output ACK0, ACK1, GNT0, GNT1, FIFO_WR_EN, FIFO_DATA, BUSY, DBG_STATE
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers,
// with bursts of up to MAX_BURST words per grant and FULL-gated writes.
module fifo_wr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input logic               SYSCLK,
    input logic               RST_B,
    fifo_wr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G0   = 2'd1,
        S_G1   = 2'd2
    } state_t;

    localparam logic [2:0] LP_CNT_LAST = 3'(MAX_BURST - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic          w_xfer0;
    logic          w_xfer1;
    logic          w_burst_done;
    logic [DW-1:0] w_fifo_data;

    // All outputs derive from r_state, so the async reset clears them at once.
    assign w_xfer0      = (r_state == S_G0) && bus.REQ0 && !bus.FULL;
    assign w_xfer1      = (r_state == S_G1) && bus.REQ1 && !bus.FULL;
    assign w_burst_done = (r_cnt == LP_CNT_LAST);

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 3'd0;
                if (bus.REQ0 && bus.REQ1) begin
                    w_state_nxt = r_last ? S_G0 : S_G1;
                end else if (bus.REQ0) begin
                    w_state_nxt = S_G0;
                end else if (bus.REQ1) begin
                    w_state_nxt = S_G1;
                end
            end
            S_G0: begin
                if (!bus.REQ0) begin
                    w_state_nxt = bus.REQ1 ? S_G1 : S_IDLE;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = 3'd0;
                end else if (w_xfer0 && w_burst_done) begin
                    // A lone requester keeps the grant across burst boundaries.
                    w_cnt_nxt = 3'd0;
                    if (bus.REQ1) begin
                        w_state_nxt = S_G1;
                        w_last_nxt  = 1'b0;
                    end
                end else if (w_xfer0) begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_G1: begin
                if (!bus.REQ1) begin
                    w_state_nxt = bus.REQ0 ? S_G0 : S_IDLE;
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = 3'd0;
                end else if (w_xfer1 && w_burst_done) begin
                    w_cnt_nxt = 3'd0;
                    if (bus.REQ0) begin
                        w_state_nxt = S_G0;
                        w_last_nxt  = 1'b1;
                    end
                end else if (w_xfer1) begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_fifo_data = '0;
        case (r_state)
            S_G0:    w_fifo_data = bus.DATA0;
            S_G1:    w_fifo_data = bus.DATA1;
            default: w_fifo_data = '0;
        endcase
    end

    assign bus.ACK0       = w_xfer0;
    assign bus.ACK1       = w_xfer1;
    assign bus.GNT0       = (r_state == S_G0);
    assign bus.GNT1       = (r_state == S_G1);
    assign bus.FIFO_WR_EN = w_xfer0 | w_xfer1;
    assign bus.FIFO_DATA  = w_fifo_data;
    assign bus.BUSY       = (r_state != S_IDLE);
    assign bus.DBG_STATE  = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: hand-computed expectations per cycle.
module tb_fifo_wr_arbiter;

  logic SYSCLK = 1'b0;
  logic RST_B  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  fifo_wr_arbiter_if #(.DW(8)) bus ();

  fifo_wr_arbiter #(.DW(8), .MAX_BURST(4)) dut (
    .SYSCLK (SYSCLK),
    .RST_B  (RST_B),
    .bus    (bus.slave)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic g0, input logic g1,
                            input logic a0, input logic a1, input logic wr,
                            input logic busy, input logic [7:0] d);
    chk({tag, ".gnt0"}, {7'd0, bus.GNT0}, {7'd0, g0});
    chk({tag, ".gnt1"}, {7'd0, bus.GNT1}, {7'd0, g1});
    chk({tag, ".ack0"}, {7'd0, bus.ACK0}, {7'd0, a0});
    chk({tag, ".ack1"}, {7'd0, bus.ACK1}, {7'd0, a1});
    chk({tag, ".wr_en"}, {7'd0, bus.FIFO_WR_EN}, {7'd0, wr});
    chk({tag, ".busy"}, {7'd0, bus.BUSY}, {7'd0, busy});
    chk({tag, ".data"}, bus.FIFO_DATA, d);
  endtask

  task automatic edge_drive();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge SYSCLK);
  endtask

  task automatic apply_reset(input logic r0, input logic r1);
    edge_drive();
    RST_B    = 1'b0;
    bus.REQ0 = r0;
    bus.REQ1 = r1;
    bus.FULL = 1'b0;
    mid();
    edge_drive();
    RST_B = 1'b1;
  endtask

  initial begin
    bus.REQ0  = 1'b0;
    bus.REQ1  = 1'b0;
    bus.DATA0 = 8'h00;
    bus.DATA1 = 8'h00;
    bus.FULL  = 1'b0;

    // reset state
    mid();
    expect_out("rst", 0, 0, 0, 0, 0, 0, 8'h00);
    edge_drive();
    RST_B = 1'b1;

    // lone requester, sustained 1 word/cycle across the burst boundary
    bus.REQ0  = 1'b1;
    bus.DATA0 = 8'h10;
    mid();
    expect_out("lone.lat", 0, 0, 0, 0, 0, 0, 8'h00);
    edge_drive();
    for (int i = 0; i < 6; i++) begin
      mid();
      expect_out($sformatf("lone.w%0d", i), 1, 0, 1, 0, 1, 1, 8'(8'h10 + i));
      edge_drive();
      bus.DATA0 = 8'(8'h11 + i);
    end
    bus.REQ0 = 1'b0;
    mid();
    expect_out("lone.rel", 1, 0, 0, 0, 0, 1, 8'h16);
    edge_drive();
    mid();
    expect_out("lone.idle", 0, 0, 0, 0, 0, 0, 8'h00);

    // contention from reset release
    bus.DATA0 = 8'hA0;
    bus.DATA1 = 8'hB0;
    apply_reset(1'b1, 1'b1);
    mid();
    expect_out("cont.lat", 0, 0, 0, 0, 0, 0, 8'h00);
    edge_drive();
    for (int i = 0; i < 4; i++) begin
      mid();
      expect_out($sformatf("cont.g0_%0d", i), 1, 0, 1, 0, 1, 1, 8'(8'hA0 + i));
      edge_drive();
      bus.DATA0 = 8'(8'hA1 + i);
    end
    for (int i = 0; i < 4; i++) begin
      mid();
      expect_out($sformatf("cont.g1_%0d", i), 0, 1, 0, 1, 1, 1, 8'(8'hB0 + i));
      edge_drive();
      bus.DATA1 = 8'(8'hB1 + i);
    end
    mid();
    expect_out("cont.back", 1, 0, 1, 0, 1, 1, 8'hA4);
    edge_drive();
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    mid();
    expect_out("cont.rel", 1, 0, 0, 0, 0, 1, 8'hA4);
    edge_drive();
    mid();
    expect_out("cont.idle", 0, 0, 0, 0, 0, 0, 8'h00);

    // backpressure mid-burst
    bus.DATA0 = 8'hC0;
    bus.DATA1 = 8'hD0;
    apply_reset(1'b1, 1'b1);
    edge_drive();
    for (int i = 0; i < 2; i++) begin
      mid();
      expect_out($sformatf("bp.pre%0d", i), 1, 0, 1, 0, 1, 1, 8'(8'hC0 + i));
      edge_drive();
      bus.DATA0 = 8'(8'hC1 + i);
    end
    bus.FULL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      expect_out($sformatf("bp.full%0d", i), 1, 0, 0, 0, 0, 1, 8'hC2);
      edge_drive();
    end
    bus.FULL = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      expect_out($sformatf("bp.post%0d", i), 1, 0, 1, 0, 1, 1, 8'(8'hC2 + i));
      edge_drive();
      bus.DATA0 = 8'(8'hC3 + i);
    end
    mid();
    expect_out("bp.sw", 0, 1, 0, 1, 1, 1, 8'hD0);

    // early release hands the port straight to requester 1
    bus.DATA0 = 8'h20;
    bus.DATA1 = 8'h30;
    apply_reset(1'b1, 1'b1);
    edge_drive();
    for (int i = 0; i < 2; i++) begin
      mid();
      expect_out($sformatf("er.g0_%0d", i), 1, 0, 1, 0, 1, 1, 8'(8'h20 + i));
      edge_drive();
      bus.DATA0 = 8'(8'h21 + i);
    end
    bus.REQ0 = 1'b0;
    mid();
    expect_out("er.drop0", 1, 0, 0, 0, 0, 1, 8'h22);
    edge_drive();
    mid();
    expect_out("er.g1", 0, 1, 0, 1, 1, 1, 8'h30);
    edge_drive();
    bus.DATA1 = 8'h31;
    bus.REQ1  = 1'b0;
    mid();
    expect_out("er.drop1", 0, 1, 0, 0, 0, 1, 8'h31);
    edge_drive();
    mid();
    expect_out("er.idle", 0, 0, 0, 0, 0, 0, 8'h00);

    // asynchronous reset in the middle of a G1 burst
    edge_drive();
    bus.REQ1  = 1'b1;
    bus.DATA1 = 8'h40;
    edge_drive();
    mid();
    expect_out("rm.g1", 0, 1, 0, 1, 1, 1, 8'h40);
    edge_drive();
    bus.DATA1 = 8'h41;
    bus.REQ0  = 1'b1;
    bus.DATA0 = 8'h50;
    #2;
    RST_B = 1'b0;
    #1;
    expect_out("rm.async", 0, 0, 0, 0, 0, 0, 8'h00);
    mid();
    edge_drive();
    RST_B = 1'b1;
    mid();
    expect_out("rm.lat", 0, 0, 0, 0, 0, 0, 8'h00);
    edge_drive();
    mid();
    expect_out("rm.g0", 1, 0, 1, 0, 1, 1, 8'h50);

    // pointer fairness: after serving requester 1 alone, a tie goes to 0
    edge_drive();
    bus.REQ0  = 1'b0;
    bus.DATA1 = 8'h60;
    mid();
    expect_out("pf.drop0", 1, 0, 0, 0, 0, 1, 8'h50);
    edge_drive();
    for (int i = 0; i < 4; i++) begin
      mid();
      expect_out($sformatf("pf.g1_%0d", i), 0, 1, 0, 1, 1, 1, 8'(8'h60 + i));
      edge_drive();
      bus.DATA1 = 8'(8'h61 + i);
    end
    bus.REQ1 = 1'b0;
    mid();
    expect_out("pf.drop1", 0, 1, 0, 0, 0, 1, 8'h64);
    edge_drive();
    bus.REQ0  = 1'b1;
    bus.REQ1  = 1'b1;
    bus.DATA0 = 8'h70;
    mid();
    expect_out("pf.idle", 0, 0, 0, 0, 0, 0, 8'h00);
    edge_drive();
    mid();
    expect_out("pf.g0", 1, 0, 1, 0, 1, 1, 8'h70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
